// File: rtl/relay_pkg.sv
// rtl/relay_pkg.sv - shared relay types, Miller symbol/state encodings and timing defaults
package relay_pkg;

  // Bit-cell timing at 13.56 MHz / 106 kbit/s
  localparam int CELL_DEF      = 128;
  localparam int HALF_DEF      = 64;
  localparam int EDGE_OFS_DEF  = 16;
  localparam int PAUSE_MIN_DEF = 4;
  localparam int BITCNT_W_DEF  = 12;

  // Modified Miller cell symbols: X = pause in second half, Y = no pause, Z = pause in first half
  typedef enum logic [1:0] {
    SYM_X = 2'd0,
    SYM_Y = 2'd1,
    SYM_Z = 2'd2
  } sym_t;

  // Reader-to-tag decoder states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_DATA = 2'd2
  } dec_state_t;

  // hi_simulate modulation modes shared with the relay datapath
  localparam logic [2:0] HISIM_MOD_NONE      = 3'd0;
  localparam logic [2:0] HISIM_MOD_BPSK      = 3'd1;
  localparam logic [2:0] HISIM_MOD_212K      = 3'd2;
  localparam logic [2:0] HISIM_MOD_424K      = 3'd4;
  localparam logic [2:0] HISIM_MOD_424K_8BIT = 3'd5;

  // Classify a finished cell from its recorded pause edge
  function automatic sym_t cell_sym(input logic has_edge, input logic late_half);
    if (!has_edge) begin
      return SYM_Y;
    end
    return late_half ? SYM_X : SYM_Z;
  endfunction

endpackage

// File: rtl/relay_pause_filter.sv
// rtl/relay_pause_filter.sv - modulation line synchroniser and pause edge filter
module relay_pause_filter
#(
  parameter int PAUSE_MIN = 4
)(
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic pause_edge
);

  localparam int CW = $clog2(PAUSE_MIN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PAUSE_MIN - 1);

  logic [1:0]    sync;
  logic          armed;
  logic [CW-1:0] low_cnt;
  logic          line;

  assign line = sync[1];

  // Synchronise the line, count consecutive low samples, fire once per pause, re-arm on high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync       <= 2'b11;
      armed      <= 1'b0;
      low_cnt    <= '0;
      pause_edge <= 1'b0;
    end else begin
      sync       <= {sync[0], data_in};
      pause_edge <= 1'b0;
      if (line) begin
        armed   <= 1'b1;
        low_cnt <= '0;
      end else if (armed) begin
        if (low_cnt == CNT_LAST) begin
          pause_edge <= 1'b1;
          armed      <= 1'b0;
          low_cnt    <= '0;
        end else begin
          low_cnt <= low_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/relay_miller_decode.sv
// rtl/relay_miller_decode.sv - ISO14443-A Modified Miller frame decoder; RELAY_MILLER_PARITY_EN adds parity_err
module relay_miller_decode
  import relay_pkg::*;
#(
  parameter int CELL      = CELL_DEF,
  parameter int HALF      = HALF_DEF,
  parameter int EDGE_OFS  = EDGE_OFS_DEF,
  parameter int PAUSE_MIN = PAUSE_MIN_DEF,
  parameter int BITCNT_W  = BITCNT_W_DEF
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                data_in,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                sof,
  output logic                eof,
  output logic                err,
  output logic                frame_active,
  output logic [BITCNT_W-1:0] bit_count
`ifdef RELAY_MILLER_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int PW = $clog2(CELL);
  localparam logic [PW-1:0] PH_LAST = PW'(CELL - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(HALF);
  localparam logic [PW-1:0] PH_Z    = PW'(EDGE_OFS);
  localparam logic [PW-1:0] PH_X    = PW'(EDGE_OFS + HALF);

  dec_state_t    state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic          cell_edge, cell_edge_nxt;
  logic          cell_x, cell_x_nxt;
  sym_t          prev_sym, prev_nxt;
  sym_t          cur_sym;
  logic          pend_valid, pend_valid_nxt;
  logic          pend_bit, pend_bit_nxt;
  logic          pause_edge;
  logic          cell_end;
  logic          late_edge;
  logic          emit, emit_bit;
  logic          sof_set, eof_set, err_set;

  relay_pause_filter #(
    .PAUSE_MIN (PAUSE_MIN)
  ) u_pause_filter (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .pause_edge (pause_edge)
  );

  // Phase tracking, cell classification and the IDLE/SOF/DATA decode decisions
  always_comb begin
    state_nxt      = state;
    phase_nxt      = (phase == PH_LAST) ? '0 : phase + 1'b1;
    cell_edge_nxt  = cell_edge;
    cell_x_nxt     = cell_x;
    prev_nxt       = prev_sym;
    pend_valid_nxt = pend_valid;
    pend_bit_nxt   = pend_bit;
    emit           = 1'b0;
    emit_bit       = 1'b0;
    sof_set        = 1'b0;
    eof_set        = 1'b0;
    err_set        = 1'b0;
    cell_end       = (phase == PH_LAST);
    // An edge on the last phase opens the next cell, so it is never a second edge
    late_edge      = pause_edge && cell_edge && !cell_end;
    cur_sym        = cell_sym(cell_edge, cell_x);

    if (cell_end) begin
      cell_edge_nxt = 1'b0;
      cell_x_nxt    = 1'b0;
    end
    if (pause_edge) begin
      cell_edge_nxt = 1'b1;
      if (cell_end || (phase < PH_HALF)) begin
        phase_nxt  = PH_Z;
        cell_x_nxt = 1'b0;
      end else begin
        phase_nxt  = PH_X;
        cell_x_nxt = 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        cell_x_nxt = 1'b0;
        if (pause_edge) begin
          state_nxt     = ST_SOF;
          phase_nxt     = PH_Z;
          cell_edge_nxt = 1'b1;
        end else begin
          cell_edge_nxt = 1'b0;
        end
      end
      ST_SOF: begin
        if (late_edge) begin
          err_set = 1'b1;
        end else if (cell_end) begin
          sof_set        = 1'b1;
          state_nxt      = ST_DATA;
          prev_nxt       = SYM_Z;
          pend_valid_nxt = 1'b0;
        end
      end
      ST_DATA: begin
        if (late_edge) begin
          err_set = 1'b1;
        end else if (cell_end) begin
          prev_nxt = cur_sym;
          case (cur_sym)
            SYM_X: begin
              emit           = pend_valid;
              emit_bit       = pend_bit;
              pend_valid_nxt = 1'b1;
              pend_bit_nxt   = 1'b1;
            end
            SYM_Z: begin
              if (prev_sym == SYM_X) begin
                err_set = 1'b1;
              end else begin
                emit           = pend_valid;
                emit_bit       = pend_bit;
                pend_valid_nxt = 1'b1;
                pend_bit_nxt   = 1'b0;
              end
            end
            default: begin
              if (prev_sym == SYM_X) begin
                emit           = pend_valid;
                emit_bit       = pend_bit;
                pend_valid_nxt = 1'b1;
                pend_bit_nxt   = 1'b0;
              end else begin
                // Pending 0 was the end-of-frame logic 0, not data
                eof_set        = 1'b1;
                state_nxt      = ST_IDLE;
                pend_valid_nxt = 1'b0;
              end
            end
          endcase
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (err_set) begin
      state_nxt      = ST_IDLE;
      pend_valid_nxt = 1'b0;
      emit           = 1'b0;
    end
    if (!enable) begin
      state_nxt      = ST_IDLE;
      pend_valid_nxt = 1'b0;
      emit           = 1'b0;
      sof_set        = 1'b0;
      eof_set        = 1'b0;
      err_set        = 1'b0;
    end
  end

  // Decoder state, pending bit and registered output strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      phase        <= '0;
      cell_edge    <= 1'b0;
      cell_x       <= 1'b0;
      prev_sym     <= SYM_Z;
      pend_valid   <= 1'b0;
      pend_bit     <= 1'b0;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      sof          <= 1'b0;
      eof          <= 1'b0;
      err          <= 1'b0;
      frame_active <= 1'b0;
      bit_count    <= '0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      cell_edge    <= cell_edge_nxt;
      cell_x       <= cell_x_nxt;
      prev_sym     <= prev_nxt;
      pend_valid   <= pend_valid_nxt;
      pend_bit     <= pend_bit_nxt;
      bit_out      <= emit & emit_bit;
      bit_valid    <= emit;
      sof          <= sof_set;
      eof          <= eof_set;
      err          <= err_set;
      frame_active <= (state_nxt != ST_IDLE);
      if (sof_set) begin
        bit_count <= '0;
      end else if (emit && (bit_count != '1)) begin
        bit_count <= bit_count + 1'b1;
      end
    end
  end

`ifdef RELAY_MILLER_PARITY_EN
  logic [3:0] par_cnt;
  logic       par_acc;

  // Every 9th bit after SOF must make the preceding byte plus itself odd
  always_ff @(posedge clk) begin
    if (reset) begin
      par_cnt    <= '0;
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (sof_set) begin
        par_cnt <= '0;
        par_acc <= 1'b0;
      end else if (emit) begin
        if (par_cnt == 4'd8) begin
          parity_err <= ~(par_acc ^ emit_bit);
          par_cnt    <= '0;
          par_acc    <= 1'b0;
        end else begin
          par_cnt <= par_cnt + 1'b1;
          par_acc <= par_acc ^ emit_bit;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_relay_miller_decode.sv
// tb/tb_relay_miller_decode.sv - self-checking bench for relay_miller_decode
module tb_relay_miller_decode;

  localparam int SX = 0;
  localparam int SY = 1;
  localparam int SZ = 2;

  typedef int sym_q_t[$];

  typedef struct {
    logic [15:0] bits;
    int          n;
    int          jit;
    int          wmin;
    int          wmax;
    int          exp_bits;
    int          exp_eof;
    int          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        data_in = 1'b1;
  logic        bit_out;
  logic        bit_valid;
  logic        sof;
  logic        eof;
  logic        err;
  logic        frame_active;
  logic [11:0] bit_count;
`ifdef RELAY_MILLER_PARITY_EN
  logic        parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int sof_n = 0;
  int eof_n = 0;
  int err_n = 0;
  int par_n = 0;
  bit fa_seen = 1'b0;
  int exp_q[$];

  relay_miller_decode dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .data_in      (data_in),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .sof          (sof),
    .eof          (eof),
    .err          (err),
    .frame_active (frame_active),
    .bit_count    (bit_count)
`ifdef RELAY_MILLER_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every decoded bit is matched against the queue filled at drive time
  always @(negedge clk) begin
    if (!reset) begin
      if (bit_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit_valid", 1, 0);
        end else begin
          check("bit_out", int'(bit_out), exp_q.pop_front());
        end
      end
      if (sof) sof_n++;
      if (eof) eof_n++;
      if (err) err_n++;
      if (frame_active) fa_seen = 1'b1;
`ifdef RELAY_MILLER_PARITY_EN
      if (parity_err) begin
        par_n++;
        check("parity_err_with_bit_valid", int'(bit_valid), 1);
      end
`endif
    end
  end

  task automatic tick(input logic v);
    @(posedge clk);
    #1;
    data_in = v;
  endtask

  task automatic build_syms(input logic [15:0] bits, input int n, output sym_q_t q);
    logic last;
    q = {};
    q.push_back(SZ);
    last = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bits[i]) q.push_back(SX);
      else         q.push_back(last ? SY : SZ);
      last = bits[i];
    end
    q.push_back(last ? SY : SZ);
    q.push_back(SY);
  endtask

  // Pauses are placed relative to the previous pause, each with its own jitter
  task automatic drive_syms(input sym_q_t syms, input int jit, input int wmin,
                            input int wmax, input int max_cells);
    int cur, t, prev_t, prev_i, ideal, w;
    bit first;
    cur = 0; prev_t = 0; prev_i = 0; first = 1'b1;
    for (int c = 0; c < syms.size() && c < max_cells; c++) begin
      if (syms[c] != SY) begin
        ideal = c * 128 + ((syms[c] == SX) ? 64 : 0);
        if (first) t = 8;
        else t = prev_t + (ideal - prev_i) + (jit != 0 ? int'($urandom_range(20)) - 10 : 0);
        w = wmin + int'($urandom_range(wmax - wmin));
        repeat (t - cur) tick(1'b1);
        repeat (w) tick(1'b0);
        cur = t + w; prev_t = t; prev_i = ideal; first = 1'b0;
      end
    end
    tick(1'b1);
  endtask

  task automatic wait_end(input int base);
    int k;
    k = 0;
    while ((eof_n + err_n == base) && (k < 2000)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) check("frame_end_timeout", 0, 1);
  endtask

  task automatic run_frame(input vec_t v);
    sym_q_t q;
    int s0, e0, r0;
    s0 = sof_n; e0 = eof_n; r0 = err_n;
    for (int i = 0; i < v.n; i++) exp_q.push_back(int'(v.bits[i]));
    build_syms(v.bits, v.n, q);
    drive_syms(q, v.jit, v.wmin, v.wmax, 1000);
    wait_end(e0 + r0);
    repeat (3) @(negedge clk);
    check("sof_pulses", sof_n - s0, 1);
    check("eof_pulses", eof_n - e0, v.exp_eof);
    check("err_pulses", err_n - r0, v.exp_err);
    check("bit_count", int'(bit_count), v.exp_bits);
    check("bits_outstanding", exp_q.size(), 0);
    check("frame_active_after", int'(frame_active), 0);
    exp_q.delete();
    repeat (20) tick(1'b1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t   vecs[5];
    sym_q_t q;
    int     s0, e0, r0, k;

    vecs[0] = '{16'h0026,  7, 0, 10, 10,  7, 1, 0};
    vecs[1] = '{16'h0005,  3, 0, 12, 12,  3, 1, 0};
    vecs[2] = '{16'hB38D, 16, 1,  5, 40, 16, 1, 0};
    vecs[3] = '{16'hFFFF, 16, 1,  5, 40, 16, 1, 0};
    vecs[4] = '{16'h0000, 16, 1,  5, 40, 16, 1, 0};

    reset = 1'b1; enable = 1'b1; data_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_bit_out", int'(bit_out), 0);
    check("reset_bit_valid", int'(bit_valid), 0);
    check("reset_sof", int'(sof), 0);
    check("reset_eof", int'(eof), 0);
    check("reset_err", int'(err), 0);
    check("reset_frame_active", int'(frame_active), 0);
    check("reset_bit_count", int'(bit_count), 0);
    repeat (10) tick(1'b1);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Too-short pause in IDLE must not start a frame
    s0 = sof_n; fa_seen = 1'b0;
    repeat (3) tick(1'b0);
    repeat (300) tick(1'b1);
    check("short_pause_sof", sof_n - s0, 0);
    check("short_pause_frame_active", int'(fa_seen), 0);

    // Z straight after X is a coding violation
    s0 = sof_n; e0 = eof_n; r0 = err_n;
    q = {SZ, SX, SZ};
    drive_syms(q, 0, 10, 10, 1000);
    k = 0;
    while ((err_n == r0) && (k < 600)) begin
      @(negedge clk);
      k++;
    end
    check("zx_err_seen", err_n - r0, 1);
    @(negedge clk);
    check("zx_frame_active_next", int'(frame_active), 0);
    check("zx_eof", eof_n - e0, 0);
    check("zx_sof", sof_n - s0, 1);
    check("zx_bits_outstanding", exp_q.size(), 0);
    repeat (300) tick(1'b1);

    // enable drops after 5 bits, then a clean frame follows
    e0 = eof_n; r0 = err_n;
    for (int i = 0; i < 5; i++) exp_q.push_back((i % 2 == 0) ? 1 : 0);
    build_syms(16'h00B5, 10, q);
    drive_syms(q, 0, 10, 10, 7);
    k = 0;
    while ((bit_count != 12'd5) && (k < 600)) begin
      @(negedge clk);
      k++;
    end
    check("abort_bit_count", int'(bit_count), 5);
    repeat (10) tick(1'b1);
    enable = 1'b0;
    repeat (20) tick(1'b1);
    check("abort_frame_active", int'(frame_active), 0);
    enable = 1'b1;
    repeat (300) tick(1'b1);
    check("abort_eof", eof_n - e0, 0);
    check("abort_err", err_n - r0, 0);
    check("abort_bits_outstanding", exp_q.size(), 0);
    run_frame('{16'h00A5, 8, 1, 5, 40, 8, 1, 0});

`ifdef RELAY_MILLER_PARITY_EN
    s0 = par_n;
    run_frame('{16'h0093, 9, 0, 10, 10, 9, 1, 0});
    check("parity_bad_pulses", par_n - s0, 1);
    s0 = par_n;
    run_frame('{16'h0193, 9, 0, 10, 10, 9, 1, 0});
    check("parity_good_pulses", par_n - s0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
